pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline; sits beside the EX forwarding unit.
//  - Detects load-use and branch-in-ID data hazards that forwarding cannot cover.
//  - Drives PC/IF_ID write enables and the IF_ID / ID_EX / EX_MEM bubbles.
//  - Runs the multi-cycle mul/div handshake (start/done) with a watchdog timeout.
// PARAMETERS
//  MD_TIMEOUT  64  max cycles in MD_WAIT before forced release and md_error
//  CNT_W       7   watchdog counter width; must satisfy 2**CNT_W > MD_TIMEOUT
// PORTS
//  clk                    in   1  system clock, rising edge
//  reset                  in   1  synchronous, active-high
//  ID_rs, ID_rt           in   5  source registers of the instruction in ID
//  ID_uses_rs, ID_uses_rt in   1  ID instruction actually reads rs / rt
//  ID_is_branch           in   1  ID holds a branch/jr that compares registers in ID
//  ID_branch_taken        in   1  branch/jump in ID resolved taken
//  ID_EX_Write_register   in   5  destination register of the EX instruction
//  ID_EX_RegWrite         in   1  EX instruction writes the register file
//  ID_EX_MemRead          in   1  EX instruction is a load
//  ID_EX_md_op            in   1  EX instruction is mul/div
//  EX_MEM_Write_register  in   5  destination register of the MEM instruction
//  EX_MEM_MemRead         in   1  MEM instruction is a load
//  md_done                in   1  mul/div unit result valid, 1-cycle pulse
//  PC_Write               out  1  1 = PC may update
//  IF_ID_Write            out  1  1 = IF_ID may load
//  IF_ID_Flush            out  1  squash IF_ID (wrong-path fetch)
//  ID_EX_Flush            out  1  insert bubble into ID_EX
//  EX_hold                out  1  freeze ID_EX and the EX instruction
//  EX_MEM_Flush           out  1  insert bubble into EX_MEM
//  md_start               out  1  1-cycle start pulse to the mul/div unit
//  md_error               out  1  sticky watchdog flag; cleared only by reset
// BEHAVIOUR
//  Reset: state=RUN, counter=0, md_error=0. While reset=1 all outputs are forced:
//   PC_Write=1, IF_ID_Write=1, every Flush/hold=0, md_start=0.
//  Matches below ignore register 0 (dest==0 never creates a hazard).
//  Hazard terms (combinational on inputs):
//   lu  = ID_EX_MemRead & dest match on a used ID source (rs&ID_uses_rs | rt&ID_uses_rt)
//   br1 = ID_is_branch & ID_EX_RegWrite & dest match on a used ID source
//   br2 = ID_is_branch & EX_MEM_MemRead & EX_MEM dest match on a used ID source
//   dstall = lu|br1|br2. br1 and br2 each stall once per cycle and recompute every cycle,
//   so load->branch stalls 2 cycles and ALU->branch stalls 1 cycle.
//  FSM states: RUN, MD_WAIT, MD_DONE.
//   RUN: ID_EX_md_op=1 -> md_start=1 this cycle, next state MD_WAIT, counter<=0.
//    md_done is ignored in RUN.
//   MD_WAIT: md_done=1 -> MD_DONE. Otherwise counter++;
//    counter==MD_TIMEOUT-1 -> md_error<=1 and next state MD_DONE.
//   MD_DONE: exactly 1 cycle, always -> RUN. md_start is never asserted here,
//    so the same op is not reissued.
//  mdfreeze = (state==MD_WAIT) | md_start.
//   EX_hold=1, EX_MEM_Flush=1, PC_Write=0, IF_ID_Write=0.
//   ID_EX_Flush=0 and IF_ID_Flush=0: freeze overrides data hazards and branch flush.
//  Else if dstall: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=0.
//  Else: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=ID_branch_taken.
//  Reset asserted mid MD_WAIT: return to RUN next edge; no md_start, no md_error.
// STRUCTURE
//  Shared package/header: state encodings (RUN=2'd0, MD_WAIT=2'd1, MD_DONE=2'd2),
//   MD_TIMEOUT default, and the register-0 constant.
//  One sub-module, md_sequencer: FSM, watchdog counter, md_start, md_error.
//   It exports mdfreeze; the parent holds the hazard compare logic and output muxing.
// TESTING
//  1. lw $8 in EX, ID add reads $8 (uses_rs) -> 1 cycle PC_Write=0, IF_ID_Write=0,
//     ID_EX_Flush=1; lw to $0 -> no stall.
//  2. lw $9 then beq on $9 -> 2 stall cycles (br1, then br2);
//     add $9 then beq $9 -> 1 stall cycle; then taken -> IF_ID_Flush=1 for 1 cycle.
//  3. mul in EX, md_done 5 cycles after md_start -> md_start 1 cycle; EX_hold=1 for 6 cycles;
//     1 MD_DONE cycle with EX_hold=0; then RUN; no second md_start.
//  4. md_done never arrives, MD_TIMEOUT=8 -> md_error=1 after 8 MD_WAIT cycles; release via
//     MD_DONE; flag stays set until reset.
//  5. mul in EX with load-use and ID_branch_taken in same cycle -> only freeze outputs;
//     ID_EX_Flush=0, IF_ID_Flush=0.
//  6. reset pulsed in cycle 3 of MD_WAIT -> RUN next cycle, outputs at reset values,
//     md_error=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline stall/flush sequencer.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_RUN  = 2'd0,
        MD_WAIT = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam int         MD_TIMEOUT_DEF = 64;
    localparam logic [4:0] REG_ZERO       = 5'd0;

    // Register 0 is hard-wired, so a write to it can never feed a consumer.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (src == dst) && (dst != REG_ZERO);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_md_sequencer.sv
// Mul/div handshake sequencer: issues md_start, waits for md_done, and
// releases the pipeline via a watchdog if the unit never answers.
module md_sequencer
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
    parameter int CNT_W      = 7
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      md_op_i,
    input  logic      md_done_i,
    output logic      md_start_o,
    output logic      md_error_o,
    output logic      mdfreeze_o,
    output md_state_e state_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Handshake: md_start is a single-cycle request issued only from RUN;
    // md_done is a single-cycle completion pulse, honoured only in MD_WAIT.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        md_start_o = 1'b0;
        unique case (state_q)
            MD_RUN: begin
                if (md_op_i && !reset) begin
                    md_start_o = 1'b1;
                    state_d    = MD_WAIT;
                    cnt_d      = '0;
                end
            end
            MD_WAIT: begin
                if (md_done_i) begin
                    state_d = MD_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        err_d   = 1'b1;
                        state_d = MD_DONE;
                    end
                end
            end
            MD_DONE: state_d = MD_RUN;
            default: state_d = MD_RUN;
        endcase
    end

    assign md_error_o = err_q;
    assign mdfreeze_o = (state_q == MD_WAIT) || md_start_o;
    assign state_o    = state_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: data hazards forwarding
// cannot cover, branch squash, and the mul/div freeze.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
    parameter int CNT_W      = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_uses_rs,
    input  logic       ID_uses_rt,
    input  logic       ID_is_branch,
    input  logic       ID_branch_taken,
    input  logic [4:0] ID_EX_Write_register,
    input  logic       ID_EX_RegWrite,
    input  logic       ID_EX_MemRead,
    input  logic       ID_EX_md_op,
    input  logic [4:0] EX_MEM_Write_register,
    input  logic       EX_MEM_MemRead,
    input  logic       md_done,
    output logic       PC_Write,
    output logic       IF_ID_Write,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Flush,
    output logic       EX_hold,
    output logic       EX_MEM_Flush,
    output logic       md_start,
    output logic       md_error
);

    logic      mdfreeze;
    md_state_e md_state;
    logic      ex_dep, mem_dep;
    logic      lu, br1, br2, dstall;

    md_sequencer #(
        .MD_TIMEOUT (MD_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_md_seq (
        .clk        (clk),
        .reset      (reset),
        .md_op_i    (ID_EX_md_op),
        .md_done_i  (md_done),
        .md_start_o (md_start),
        .md_error_o (md_error),
        .mdfreeze_o (mdfreeze),
        .state_o    (md_state)
    );

    assign ex_dep  = (ID_uses_rs && reg_match(ID_rs, ID_EX_Write_register)) ||
                     (ID_uses_rt && reg_match(ID_rt, ID_EX_Write_register));
    assign mem_dep = (ID_uses_rs && reg_match(ID_rs, EX_MEM_Write_register)) ||
                     (ID_uses_rt && reg_match(ID_rt, EX_MEM_Write_register));

    // Branches compare in ID, so they also wait on ALU results and on loads in MEM.
    assign lu     = ID_EX_MemRead && ex_dep;
    assign br1    = ID_is_branch && ID_EX_RegWrite && ex_dep;
    assign br2    = ID_is_branch && EX_MEM_MemRead && mem_dep;
    assign dstall = lu || br1 || br2;

    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_hold      = 1'b0;
        EX_MEM_Flush = 1'b0;
        if (reset) begin
            PC_Write    = 1'b1;
            IF_ID_Write = 1'b1;
        end else if (mdfreeze) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            EX_hold      = 1'b1;
            EX_MEM_Flush = 1'b1;
        end else if (dstall) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end else begin
            IF_ID_Flush = ID_branch_taken;
        end
    end

    // The held op must not be reissued on its release cycle.
    always_comb begin
        if (!reset) assert (!((md_state == MD_DONE) && md_start));
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: hazard vector table plus
// hand-written multi-cycle sequences for the mul/div sequencer.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ID_rs, ID_rt;
    logic       ID_uses_rs, ID_uses_rt, ID_is_branch, ID_branch_taken;
    logic [4:0] ID_EX_Write_register;
    logic       ID_EX_RegWrite, ID_EX_MemRead, ID_EX_md_op;
    logic [4:0] EX_MEM_Write_register;
    logic       EX_MEM_MemRead, md_done;
    logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush;
    logic       EX_hold, EX_MEM_Flush, md_start, md_error;

    int total = 0;
    int bad   = 0;

    // Output vector order: PC_Write IF_ID_Write IF_ID_Flush ID_EX_Flush EX_hold EX_MEM_Flush md_start md_error
    localparam logic [7:0] O_RUN   = 8'b1100_0000;
    localparam logic [7:0] O_STALL = 8'b0001_0000;
    localparam logic [7:0] O_TAKEN = 8'b1110_0000;
    localparam logic [7:0] O_START = 8'b0000_1110;
    localparam logic [7:0] O_FRZ   = 8'b0000_1100;
    localparam logic [7:0] O_ERR   = 8'b0000_0001;

    logic [7:0] act;
    assign act = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
                  EX_hold, EX_MEM_Flush, md_start, md_error};

    pipeline_hazard_ctrl #(
        .MD_TIMEOUT (8),
        .CNT_W      (4)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .ID_rs                 (ID_rs),
        .ID_rt                 (ID_rt),
        .ID_uses_rs            (ID_uses_rs),
        .ID_uses_rt            (ID_uses_rt),
        .ID_is_branch          (ID_is_branch),
        .ID_branch_taken       (ID_branch_taken),
        .ID_EX_Write_register  (ID_EX_Write_register),
        .ID_EX_RegWrite        (ID_EX_RegWrite),
        .ID_EX_MemRead         (ID_EX_MemRead),
        .ID_EX_md_op           (ID_EX_md_op),
        .EX_MEM_Write_register (EX_MEM_Write_register),
        .EX_MEM_MemRead        (EX_MEM_MemRead),
        .md_done               (md_done),
        .PC_Write              (PC_Write),
        .IF_ID_Write           (IF_ID_Write),
        .IF_ID_Flush           (IF_ID_Flush),
        .ID_EX_Flush           (ID_EX_Flush),
        .EX_hold               (EX_hold),
        .EX_MEM_Flush          (EX_MEM_Flush),
        .md_start              (md_start),
        .md_error              (md_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       br;
        logic       tkn;
        logic [4:0] ex_dst;
        logic       ex_rw;
        logic       ex_mr;
        logic [4:0] mem_dst;
        logic       mem_mr;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic idle_inputs();
        ID_rs = '0; ID_rt = '0; ID_uses_rs = 0; ID_uses_rt = 0;
        ID_is_branch = 0; ID_branch_taken = 0;
        ID_EX_Write_register = '0; ID_EX_RegWrite = 0; ID_EX_MemRead = 0; ID_EX_md_op = 0;
        EX_MEM_Write_register = '0; EX_MEM_MemRead = 0; md_done = 0;
    endtask

    task automatic apply_vec(input vec_t v);
        ID_rs = v.rs; ID_rt = v.rt; ID_uses_rs = v.use_rs; ID_uses_rt = v.use_rt;
        ID_is_branch = v.br; ID_branch_taken = v.tkn;
        ID_EX_Write_register = v.ex_dst; ID_EX_RegWrite = v.ex_rw; ID_EX_MemRead = v.ex_mr;
        EX_MEM_Write_register = v.mem_dst; EX_MEM_MemRead = v.mem_mr;
    endtask

    // Inputs are set just after a rising edge; outputs are checked on the falling edge.
    task automatic cycle(input string name, input logic [7:0] exp);
        @(negedge clk);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rs rt urs urt br tkn exdst rw mr memdst mmr
        vecs[0]  = '{"lu_rs",        5'd8, 5'd0, 1, 0, 0, 0, 5'd8, 1, 1, 5'd0, 0, O_STALL};
        vecs[1]  = '{"lu_r0",        5'd0, 5'd0, 1, 1, 0, 0, 5'd0, 1, 1, 5'd0, 0, O_RUN};
        vecs[2]  = '{"lu_rt_unused", 5'd1, 5'd8, 1, 0, 0, 0, 5'd8, 1, 1, 5'd0, 0, O_RUN};
        vecs[3]  = '{"lu_rt",        5'd1, 5'd8, 1, 1, 0, 0, 5'd8, 1, 1, 5'd0, 0, O_STALL};
        vecs[4]  = '{"alu_fwd",      5'd9, 5'd0, 1, 0, 0, 0, 5'd9, 1, 0, 5'd0, 0, O_RUN};
        vecs[5]  = '{"br1",          5'd9, 5'd0, 1, 0, 1, 0, 5'd9, 1, 0, 5'd0, 0, O_STALL};
        vecs[6]  = '{"br2",          5'd2, 5'd9, 1, 1, 1, 0, 5'd0, 0, 0, 5'd9, 1, O_STALL};
        vecs[7]  = '{"mem_ld_nonbr", 5'd9, 5'd0, 1, 0, 0, 0, 5'd0, 0, 0, 5'd9, 1, O_RUN};
        vecs[8]  = '{"taken",        5'd3, 5'd4, 1, 1, 1, 1, 5'd5, 1, 0, 5'd6, 1, O_TAKEN};
        vecs[9]  = '{"taken_br1",    5'd3, 5'd4, 1, 1, 1, 1, 5'd4, 1, 0, 5'd0, 0, O_STALL};
        vecs[10] = '{"br2_r0",       5'd0, 5'd0, 1, 1, 1, 0, 5'd0, 0, 0, 5'd0, 1, O_RUN};
        vecs[11] = '{"br_nodep",     5'd6, 5'd0, 1, 0, 1, 0, 5'd5, 1, 1, 5'd0, 0, O_RUN};

        // Reset with a live load-use hazard: outputs must stay at reset values.
        idle_inputs();
        reset = 1;
        ID_rs = 5'd8; ID_uses_rs = 1; ID_EX_Write_register = 5'd8; ID_EX_MemRead = 1;
        @(posedge clk); #1;
        cycle("reset_forced", O_RUN);
        reset = 0;
        idle_inputs();
        cycle("post_reset", O_RUN);

        for (int i = 0; i < 12; i++) begin
            apply_vec(vecs[i]);
            cycle(vecs[i].name, vecs[i].exp);
        end

        // lw $9 then beq $9: stall in EX (br1), stall in MEM (br2), then resolve taken.
        idle_inputs();
        ID_rs = 5'd9; ID_uses_rs = 1; ID_is_branch = 1;
        ID_EX_Write_register = 5'd9; ID_EX_RegWrite = 1; ID_EX_MemRead = 1;
        cycle("lw_beq_s1", O_STALL);
        ID_EX_Write_register = 5'd0; ID_EX_RegWrite = 0; ID_EX_MemRead = 0;
        EX_MEM_Write_register = 5'd9; EX_MEM_MemRead = 1;
        cycle("lw_beq_s2", O_STALL);
        EX_MEM_Write_register = 5'd0; EX_MEM_MemRead = 0; ID_branch_taken = 1;
        cycle("lw_beq_take", O_TAKEN);
        idle_inputs();
        cycle("lw_beq_after", O_RUN);

        // add $9 then beq $9: one stall, then no stall with the add in MEM.
        ID_rs = 5'd9; ID_uses_rs = 1; ID_is_branch = 1;
        ID_EX_Write_register = 5'd9; ID_EX_RegWrite = 1;
        cycle("add_beq_s1", O_STALL);
        ID_EX_Write_register = 5'd0; ID_EX_RegWrite = 0;
        EX_MEM_Write_register = 5'd9; ID_branch_taken = 1;
        cycle("add_beq_take", O_TAKEN);
        idle_inputs();
        cycle("add_beq_after", O_RUN);

        // mul with md_done 5 cycles after md_start.
        ID_EX_md_op = 1;
        cycle("mul_start", O_START);
        for (int i = 1; i <= 4; i++) cycle("mul_wait", O_FRZ);
        md_done = 1;
        cycle("mul_done_cyc", O_FRZ);
        md_done = 0;
        cycle("mul_release", O_RUN);
        ID_EX_md_op = 0;
        cycle("mul_run", O_RUN);
        cycle("mul_run2", O_RUN);

        // Freeze overrides load-use and branch flush; the stall surfaces after release.
        ID_EX_md_op = 1; ID_rs = 5'd8; ID_uses_rs = 1; ID_is_branch = 1; ID_branch_taken = 1;
        ID_EX_Write_register = 5'd8; ID_EX_MemRead = 1;
        cycle("frz_ovr_start", O_START);
        cycle("frz_ovr_wait", O_FRZ);
        md_done = 1;
        cycle("frz_ovr_done", O_FRZ);
        md_done = 0;
        cycle("frz_ovr_release", O_STALL);
        idle_inputs();
        cycle("frz_ovr_idle", O_RUN);

        // Watchdog: no md_done, 8 MD_WAIT cycles then forced release with sticky error.
        ID_EX_md_op = 1;
        cycle("wd_start", O_START);
        for (int i = 1; i <= 8; i++) cycle("wd_wait", O_FRZ);
        cycle("wd_release", O_RUN | O_ERR);
        ID_EX_md_op = 0;
        for (int i = 0; i < 3; i++) cycle("wd_sticky", O_RUN | O_ERR);
        md_done = 1;
        cycle("wd_late_done", O_RUN | O_ERR);
        md_done = 0;
        reset = 1;
        cycle("wd_reset_cyc", O_RUN | O_ERR);
        reset = 0;
        cycle("wd_cleared", O_RUN);

        // Reset in the third MD_WAIT cycle aborts the op without error or reissue.
        ID_EX_md_op = 1;
        cycle("rst_start", O_START);
        cycle("rst_wait1", O_FRZ);
        cycle("rst_wait2", O_FRZ);
        reset = 1;
        cycle("rst_in_wait", O_RUN);
        reset = 0;
        ID_EX_md_op = 0;
        cycle("rst_back_run", O_RUN);
        cycle("rst_idle", O_RUN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
